// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
//
// Purpose:
//    Bundles every handshake and data bus around the ID/EX ALU issue
//    register so the stage and its environment connect through a single
//    port. Clock and reset are not part of the bundle.
//
// Signal summary:
//    ID side     : id_valid, id_ready, id_opcode, id_funct, id_shamt,
//                  id_imm, id_rs, id_rt, id_rd, id_rs_data, id_rt_data
//    EX/MEM fwd  : exm_regwrite, exm_is_load, exm_rd, exm_result
//    MEM/WB fwd  : wb_regwrite, wb_rd, wb_result
//    Control     : flush
//    EX side     : ex_ready, ex_valid, Operand1, Operand2, ALUControl,
//                  shiftAmount, ex_dest, ex_regwrite, ex_illegal
//    Status      : stall_count
//
// Modports:
//    slave  - the issue stage itself
//    master - the surrounding pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);

    logic                  id_valid;
    logic                  id_ready;
    logic [5:0]            id_opcode;
    logic [5:0]            id_funct;
    logic [4:0]            id_shamt;
    logic [15:0]           id_imm;
    logic [4:0]            id_rs;
    logic [4:0]            id_rt;
    logic [4:0]            id_rd;
    logic [DW-1:0]         id_rs_data;
    logic [DW-1:0]         id_rt_data;

    logic                  exm_regwrite;
    logic                  exm_is_load;
    logic [4:0]            exm_rd;
    logic [DW-1:0]         exm_result;

    logic                  wb_regwrite;
    logic [4:0]            wb_rd;
    logic [DW-1:0]         wb_result;

    logic                  flush;

    logic                  ex_ready;
    logic                  ex_valid;
    logic signed [DW-1:0]  Operand1;
    logic signed [DW-1:0]  Operand2;
    logic [3:0]            ALUControl;
    logic [4:0]            shiftAmount;
    logic [4:0]            ex_dest;
    logic                  ex_regwrite;
    logic                  ex_illegal;

    logic [CNT_W-1:0]      stall_count;

    modport slave (
        input  id_valid, id_opcode, id_funct, id_shamt, id_imm,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               exm_regwrite, exm_is_load, exm_rd, exm_result,
               wb_regwrite, wb_rd, wb_result,
               flush, ex_ready,
        output id_ready, ex_valid, Operand1, Operand2, ALUControl,
               shiftAmount, ex_dest, ex_regwrite, ex_illegal, stall_count
    );

    modport master (
        output id_valid, id_opcode, id_funct, id_shamt, id_imm,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               exm_regwrite, exm_is_load, exm_rd, exm_result,
               wb_regwrite, wb_rd, wb_result,
               flush, ex_ready,
        input  id_ready, ex_valid, Operand1, Operand2, ALUControl,
               shiftAmount, ex_dest, ex_regwrite, ex_illegal, stall_count
    );

endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//    ID/EX issue register feeding a 32-bit ALU. Each cycle it may accept one
//    decoded instruction from ID, map opcode/funct onto the 4-bit ALU code
//    set, resolve source operands with EX/MEM and MEM/WB forwarding, and
//    register the result toward EX under a valid/ready handshake. It also
//    detects load-use hazards and keeps a saturating count of stall cycles.
//
// Ports:
//    clk    - rising-edge clock
//    reset  - asynchronous, active-low reset
//    bus    - alu_issue_stage_if.slave carrying the ID, forwarding, flush,
//             EX handshake and status signals
//
// Parameters:
//    DW     - datapath width of operands and forwarding buses
//    CNT_W  - width of the saturating stall counter
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.slave   bus
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Decoded view of the instruction currently offered by ID.
    logic [3:0]       decAlu;
    logic             decUseImm;
    logic             decSignExt;
    logic             decRtIsSource;
    logic             decRegWrite;
    logic             decDestRd;
    logic             decIllegal;

    // Operand datapath.
    logic [DW-1:0]    rsFwd;
    logic [DW-1:0]    rtFwd;
    logic [DW-1:0]    immSext;
    logic [DW-1:0]    immZext;
    logic [DW-1:0]    op1Dec;
    logic [DW-1:0]    op2Dec;
    logic [4:0]       destDec;

    // Handshake.
    logic             hazard;
    logic             idReady;
    logic             xfer;

    // Issue register.
    logic             valid_q,    valid_d;
    logic [DW-1:0]    op1_q,      op1_d;
    logic [DW-1:0]    op2_q,      op2_d;
    logic [3:0]       aluCtrl_q,  aluCtrl_d;
    logic [4:0]       shamt_q,    shamt_d;
    logic [4:0]       dest_q,     dest_d;
    logic             regWrite_q, regWrite_d;
    logic             illegal_q,  illegal_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    // Instruction decode: pick the ALU operation, whether Operand2 comes
    // from the immediate (and how it is extended), which register is the
    // destination, and whether rt is read as a source. Unknown encodings
    // become a harmless ADD of zeros that writes nothing.
    always_comb begin
        decAlu        = ALU_ADD;
        decUseImm     = 1'b0;
        decSignExt    = 1'b0;
        decRtIsSource = 1'b0;
        decRegWrite   = 1'b0;
        decDestRd     = 1'b0;
        decIllegal    = 1'b0;
        case (bus.id_opcode)
            OP_RTYPE: begin
                decRtIsSource = 1'b1;
                decDestRd     = 1'b1;
                decRegWrite   = 1'b1;
                case (bus.id_funct)
                    6'h20, 6'h21: decAlu = ALU_ADD;
                    6'h22, 6'h23: decAlu = ALU_SUB;
                    6'h24:        decAlu = ALU_AND;
                    6'h25:        decAlu = ALU_OR;
                    default: begin
                        decIllegal  = 1'b1;
                        decRegWrite = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                decUseImm   = 1'b1;
                decSignExt  = 1'b1;
                decRegWrite = 1'b1;
            end
            OP_SW: begin
                // The store data register is read, so rt is a source here.
                decUseImm     = 1'b1;
                decSignExt    = 1'b1;
                decRtIsSource = 1'b1;
            end
            OP_ANDI: begin
                decAlu      = ALU_AND;
                decUseImm   = 1'b1;
                decRegWrite = 1'b1;
            end
            OP_ORI: begin
                decAlu      = ALU_OR;
                decUseImm   = 1'b1;
                decRegWrite = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                decAlu        = ALU_SUB;
                decRtIsSource = 1'b1;
            end
            default: begin
                decIllegal = 1'b1;
            end
        endcase
    end

    // Operand forwarding. EX/MEM holds the youngest value so it is checked
    // first; register $0 is hard-wired to zero and is never forwarded.
    always_comb begin
        rsFwd = bus.id_rs_data;
        if (bus.exm_regwrite && (bus.exm_rd == bus.id_rs) && (bus.id_rs != 5'd0)) begin
            rsFwd = bus.exm_result;
        end else if (bus.wb_regwrite && (bus.wb_rd == bus.id_rs) && (bus.id_rs != 5'd0)) begin
            rsFwd = bus.wb_result;
        end

        rtFwd = bus.id_rt_data;
        if (bus.exm_regwrite && (bus.exm_rd == bus.id_rt) && (bus.id_rt != 5'd0)) begin
            rtFwd = bus.exm_result;
        end else if (bus.wb_regwrite && (bus.wb_rd == bus.id_rt) && (bus.id_rt != 5'd0)) begin
            rtFwd = bus.wb_result;
        end
    end

    assign immSext = {{(DW-16){bus.id_imm[15]}}, bus.id_imm};
    assign immZext = {{(DW-16){1'b0}}, bus.id_imm};

    // Final operand and destination selection for the register inputs.
    always_comb begin
        op1Dec  = rsFwd;
        op2Dec  = rtFwd;
        destDec = bus.id_rt;
        if (decUseImm) begin
            op2Dec = decSignExt ? immSext : immZext;
        end
        if (decDestRd) begin
            destDec = bus.id_rd;
        end
        if (decIllegal) begin
            op1Dec  = '0;
            op2Dec  = '0;
            destDec = 5'd0;
        end
    end

    // A load in EX/MEM cannot forward its data in time, so any consumer of
    // its destination must wait. rt only matters when it is actually read.
    assign hazard = bus.id_valid & bus.exm_is_load & bus.exm_regwrite &
                    (bus.exm_rd != 5'd0) &
                    ((bus.exm_rd == bus.id_rs) |
                     (decRtIsSource & (bus.exm_rd == bus.id_rt)));

    assign idReady = ~hazard & (~valid_q | bus.ex_ready);
    assign xfer    = bus.id_valid & idReady;

    // Next-state for the issue register. Flush wins over a transfer; a held
    // instruction keeps every field stable; the payload is only loaded on
    // a real transfer so later forward-bus changes cannot disturb it.
    always_comb begin
        valid_d    = valid_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        aluCtrl_d  = aluCtrl_q;
        shamt_d    = shamt_q;
        dest_d     = dest_q;
        regWrite_d = regWrite_q;
        illegal_d  = illegal_q;
        stallCnt_d = stallCnt_q;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d    = 1'b1;
            op1_d      = op1Dec;
            op2_d      = op2Dec;
            aluCtrl_d  = decAlu;
            shamt_d    = bus.id_shamt;
            dest_d     = destDec;
            regWrite_d = decRegWrite;
            illegal_d  = decIllegal;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end

        // Stall counter saturates at all-ones instead of wrapping.
        if (hazard && !bus.flush && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // State register; reset clears every output register, counter included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            aluCtrl_q  <= ALU_ADD;
            shamt_q    <= 5'd0;
            dest_q     <= 5'd0;
            regWrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            aluCtrl_q  <= aluCtrl_d;
            shamt_q    <= shamt_d;
            dest_q     <= dest_d;
            regWrite_q <= regWrite_d;
            illegal_q  <= illegal_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.id_ready    = idReady;
    assign bus.ex_valid    = valid_q;
    assign bus.Operand1    = op1_q;
    assign bus.Operand2    = op2_q;
    assign bus.ALUControl  = aluCtrl_q;
    assign bus.shiftAmount = shamt_q;
    assign bus.ex_dest     = dest_q;
    assign bus.ex_regwrite = regWrite_q;
    assign bus.ex_illegal  = illegal_q;
    assign bus.stall_count = stallCnt_q;

endmodule
